eth_port_ingress: RTL and testbench

ETH_PORT_INGRESS -- requirements
Module: eth_port_ingress

---
 rtl/eth_port_ingress.sv | 168 ++++++++++++++++
 tb/tb_eth_port_ingress.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_port_ingress.sv
// Ingress buffer for one switch port. Incoming frames are checked for a known
// destination address, then buffered store-and-forward. A frame becomes visible
// to the switch core only after its last word is written. Frames that cannot be
// delivered are discarded and counted.
module eth_port_ingress #(
    parameter int unsigned DEPTH        = 32,
    parameter logic [31:0] PORTA_ADDR   = 32'hABCDABCD,
    parameter logic [31:0] PORTB_ADDR   = 32'hBABEBABE,
    parameter int unsigned STALL_THRESH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_data,
    input  logic        i_start,
    input  logic        i_end,
    output logic        o_stall,
    output logic [31:0] o_data,
    output logic        o_start,
    output logic        o_end,
    output logic        o_dest,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_DEPTH = DEPTH[AW:0];

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Entry layout: {start, end, dest, data}
    logic [34:0] mem_q [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] cm_ptr_q, cm_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        stall_q, stall_d;

    logic        we;
    logic [AW:0] wr_addr;
    logic [AW:0] start_base;
    logic        do_start;
    logic [1:0]  drop_inc;
    logic        addr_hit;
    logic        dest_b;
    logic [34:0] head;
    logic [16:0] cnt_sum;
    logic [AW:0] occ_d;

    // Occupancy is measured against rd_ptr before this cycle's read, so a read
    // in the same cycle never makes room for the incoming word.
    function automatic logic is_full(input logic [AW:0] base, input logic [AW:0] rd);
        return (base - rd) == PTR_DEPTH;
    endfunction

    assign dest_b   = (i_data == PORTB_ADDR);
    assign addr_hit = (i_data == PORTA_ADDR) || dest_b;

    // Receive FSM: decides write, rollback, commit and drops for this cycle.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        we         = 1'b0;
        wr_addr    = wr_ptr_q;
        start_base = wr_ptr_q;
        do_start   = 1'b0;
        drop_inc   = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) do_start = 1'b1;
            end
            ST_RECV: begin
                if (i_start) begin
                    // Truncated frame: discard it, then treat this word as a new start.
                    drop_inc   = 2'd1;
                    wr_ptr_d   = cm_ptr_q;
                    start_base = cm_ptr_q;
                    do_start   = 1'b1;
                end else if (is_full(wr_ptr_q, rd_ptr_q)) begin
                    drop_inc = 2'd1;
                    wr_ptr_d = cm_ptr_q;
                    state_d  = i_end ? ST_IDLE : ST_DISCARD;
                end else begin
                    we       = 1'b1;
                    wr_addr  = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (i_end) begin
                        cm_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (i_start)    do_start = 1'b1;
                else if (i_end) state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_start) begin
            if (i_end) begin
                // Single-word runt.
                drop_inc = drop_inc + 2'd1;
                state_d  = ST_IDLE;
            end else if (addr_hit && !is_full(start_base, rd_ptr_q)) begin
                we       = 1'b1;
                wr_addr  = start_base;
                wr_ptr_d = start_base + 1'b1;
                state_d  = ST_RECV;
            end else begin
                drop_inc = drop_inc + 2'd1;
                state_d  = ST_DISCARD;
            end
        end
    end

    // Read side, saturating drop counter and next-cycle stall.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + ((o_valid && i_ready) ? 1'b1 : 1'b0);
        cnt_sum    = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        occ_d      = wr_ptr_d - rd_ptr_d;
        stall_d    = (DEPTH - 32'(occ_d)) < STALL_THRESH;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // Storage array; contents are meaningless until committed, so no reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr[AW-1:0]] <= {i_start, i_end, dest_b, i_data};
    end

    // Head outputs are forced to zero whenever nothing committed is present.
    always_comb begin
        o_valid = (rd_ptr_q != cm_ptr_q);
        head    = mem_q[rd_ptr_q[AW-1:0]];
        o_data  = o_valid ? head[31:0] : 32'd0;
        o_start = o_valid & head[34];
        o_end   = o_valid & head[33];
        o_dest  = o_valid & head[32];
    end

    assign o_stall    = stall_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_port_ingress.sv
// Self-checking bench for eth_port_ingress: a vector table, directed corner
// sequences and randomized traffic, all compared against a frame-queue model.
module tb_eth_port_ingress;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned THRESH = 8;
    localparam logic [31:0] ADDR_A = 32'hABCDABCD;
    localparam logic [31:0] ADDR_B = 32'hBABEBABE;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_start = 1'b0;
    logic        i_end = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_stall;
    logic [31:0] o_data;
    logic        o_start;
    logic        o_end;
    logic        o_dest;
    logic        o_valid;
    logic [15:0] o_drop_cnt;

    int tests = 0;
    int fails = 0;

    eth_port_ingress #(
        .DEPTH       (DEPTH),
        .PORTA_ADDR  (ADDR_A),
        .PORTB_ADDR  (ADDR_B),
        .STALL_THRESH(THRESH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_data    (i_data),
        .i_start   (i_start),
        .i_end     (i_end),
        .o_stall   (o_stall),
        .o_data    (o_data),
        .o_start   (o_start),
        .o_end     (o_end),
        .o_dest    (o_dest),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: committed words (cq) and the frame being collected (pq).
    // Entry = {start, end, dest, data}.
    logic [34:0] cq[$];
    logic [34:0] pq[$];
    bit          m_recv;
    bit          m_disc;
    int          m_drops;
    bit          m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void m_clear();
        cq.delete();
        pq.delete();
        m_recv  = 0;
        m_disc  = 0;
        m_drops = 0;
        m_stall = 0;
    endfunction

    function automatic void m_start(input logic [31:0] d, input bit e);
        m_recv = 0;
        m_disc = 0;
        if (e) begin
            m_drops++;
        end else if ((d == ADDR_A || d == ADDR_B) && (cq.size() + pq.size() < DEPTH)) begin
            pq.push_back({1'b1, 1'b0, d == ADDR_B, d});
            m_recv = 1;
        end else begin
            m_drops++;
            m_disc = 1;
        end
    endfunction

    function automatic void m_step(input logic [31:0] d, input bit s, input bit e, input bit r);
        bit pop;
        pop = (cq.size() != 0) && r;
        if (m_recv) begin
            if (s) begin
                m_drops++;
                pq.delete();
                m_start(d, e);
            end else if (cq.size() + pq.size() == DEPTH) begin
                m_drops++;
                pq.delete();
                m_recv = 0;
                m_disc = !e;
            end else begin
                pq.push_back({1'b0, e, 1'b0, d});
                if (e) begin
                    foreach (pq[k]) cq.push_back(pq[k]);
                    pq.delete();
                    m_recv = 0;
                end
            end
        end else if (s) begin
            m_start(d, e);
        end else if (m_disc && e) begin
            m_disc = 0;
        end
        if (pop) void'(cq.pop_front());
        m_stall = (DEPTH - (cq.size() + pq.size())) < THRESH;
    endfunction

    task automatic check_model();
        logic [34:0] h;
        chk("valid", 32'(o_valid), 32'(cq.size() != 0));
        if (cq.size() != 0) begin
            h = cq[0];
            chk("data", o_data, h[31:0]);
            chk("start", 32'(o_start), 32'(h[34]));
            chk("end", 32'(o_end), 32'(h[33]));
            if (h[34]) chk("dest", 32'(o_dest), 32'(h[32]));
        end
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drops));
        chk("stall", 32'(o_stall), 32'(m_stall));
    endtask

    // One clock: drive inputs, step model at the edge, compare at the next negedge.
    task automatic cycle(input logic [31:0] d, input bit s, input bit e, input bit r);
        i_data  = d;
        i_start = s;
        i_end   = e;
        i_ready = r;
        @(posedge clk);
        m_step(d, s, e, r);
        @(negedge clk);
        check_model();
    endtask

    task automatic reset_now();
        rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_flags", {29'd0, o_start, o_end, o_dest}, 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        m_clear();
        i_data  = '0;
        i_start = 1'b0;
        i_end   = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] addr, input int n, input bit r);
        for (int i = 0; i < n; i++)
            cycle((i == 0) ? addr : 32'h5000_0000 + 32'(i), i == 0, i == n - 1, r);
    endtask

    task automatic drain(output int words, output logic [31:0] first);
        words = 0;
        first = '0;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            if (o_valid) begin
                if (words == 0) first = o_data;
                words++;
            end
            cycle(32'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        bit          s;
        bit          e;
        bit          r;
        bit          ev;
        logic [31:0] ed;
        bit          es;
        bit          ee;
        bit          edst;
        int          edrop;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          words;
        logic [31:0] first;
        bit          seen;

        m_clear();
        @(negedge clk);
        @(negedge clk);
        reset_now();
        check_model();

        // Nominal A frame, then a bad-destination frame followed by a B frame.
        tbl.push_back('{ADDR_A,       1, 0, 1, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{32'h11111111, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{32'hA0000001, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{32'hA0000002, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{32'hA0000003, 0, 1, 1, 1, ADDR_A,       1, 0, 0, 0});
        tbl.push_back('{32'h0,        0, 0, 1, 1, 32'h11111111, 0, 0, 0, 0});
        tbl.push_back('{32'h0,        0, 0, 1, 1, 32'hA0000001, 0, 0, 0, 0});
        tbl.push_back('{32'h0,        0, 0, 1, 1, 32'hA0000002, 0, 0, 0, 0});
        tbl.push_back('{32'h0,        0, 0, 1, 1, 32'hA0000003, 0, 1, 0, 0});
        tbl.push_back('{32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{32'h12345678, 1, 0, 1, 0, 32'h0,        0, 0, 0, 1});
        tbl.push_back('{32'h22222222, 0, 0, 1, 0, 32'h0,        0, 0, 0, 1});
        tbl.push_back('{32'h33333333, 0, 1, 1, 0, 32'h0,        0, 0, 0, 1});
        tbl.push_back('{ADDR_B,       1, 0, 1, 0, 32'h0,        0, 0, 0, 1});
        tbl.push_back('{32'hB1B1B1B1, 0, 1, 1, 1, ADDR_B,       1, 0, 1, 1});
        tbl.push_back('{32'h0,        0, 0, 1, 1, 32'hB1B1B1B1, 0, 1, 0, 1});
        tbl.push_back('{32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0, 1});

        foreach (tbl[i]) begin
            cycle(tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].r);
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), o_data, tbl[i].ed);
                chk($sformatf("vec%0d_start", i), 32'(o_start), 32'(tbl[i].es));
                chk($sformatf("vec%0d_end", i), 32'(o_end), 32'(tbl[i].ee));
                if (tbl[i].es) chk($sformatf("vec%0d_dest", i), 32'(o_dest), 32'(tbl[i].edst));
            end
            chk($sformatf("vec%0d_drop", i), 32'(o_drop_cnt), 32'(tbl[i].edrop));
        end

        // Two back-to-back 20-word frames with the core stalled.
        reset_now();
        send_frame(ADDR_A, 20, 1'b0);
        cycle(ADDR_A, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) cycle(32'h6000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("ovf_stall_when_full", 32'(o_stall), 32'd1);
        for (int i = 12; i < 20; i++) cycle(32'h6000_0000 + 32'(i), 1'b0, i == 19, 1'b0);
        chk("ovf_drop", 32'(o_drop_cnt), 32'd1);
        drain(words, first);
        chk("ovf_words", 32'(words), 32'd20);
        chk("ovf_first", first, ADDR_A);

        // New start on word 3 truncates the frame in progress.
        reset_now();
        cycle(ADDR_A, 1'b1, 1'b0, 1'b1);
        cycle(32'h70000001, 1'b0, 1'b0, 1'b1);
        cycle(32'h70000002, 1'b0, 1'b0, 1'b1);
        cycle(ADDR_B, 1'b1, 1'b0, 1'b1);
        cycle(32'h80000001, 1'b0, 1'b0, 1'b1);
        cycle(32'h80000002, 1'b0, 1'b1, 1'b1);
        chk("trunc_drop", 32'(o_drop_cnt), 32'd1);
        chk("trunc_dest", 32'(o_dest), 32'd1);
        drain(words, first);
        chk("trunc_words", 32'(words), 32'd3);
        chk("trunc_first", first, ADDR_B);

        // Runt followed by an over-long frame: nothing is ever presented.
        reset_now();
        seen = 0;
        cycle(ADDR_A, 1'b1, 1'b1, 1'b1);
        seen |= o_valid;
        for (int i = 0; i < 40; i++) begin
            cycle((i == 0) ? ADDR_A : 32'(i), i == 0, i == 39, 1'b1);
            seen |= o_valid;
        end
        chk("long_drop", 32'(o_drop_cnt), 32'd2);
        chk("long_never_valid", 32'(seen), 32'd0);

        // Reset mid-frame with a committed frame queued.
        reset_now();
        send_frame(ADDR_A, 4, 1'b0);
        chk("mid_rst_pre_valid", 32'(o_valid), 32'd1);
        cycle(ADDR_B, 1'b1, 1'b0, 1'b0);
        i_data  = 32'h90000001;
        i_start = 1'b0;
        i_end   = 1'b0;
        #2;
        reset_now();
        seen = 0;
        cycle(32'h90000002, 1'b0, 1'b0, 1'b1);
        seen |= o_valid;
        cycle(32'h90000003, 1'b0, 1'b1, 1'b1);
        seen |= o_valid;
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        send_frame(ADDR_A, 3, 1'b1);
        drain(words, first);
        chk("mid_rst_words", 32'(words), 32'd3);

        // Randomized traffic: a free-flowing phase, then a congested one.
        reset_now();
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                bit          s;
                bit          e;
                bit          r;
                logic [31:0] d;
                int          pick;
                s = ($urandom_range(0, 7) == 0);
                e = ($urandom_range(0, 6) == 0);
                r = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                d = $urandom;
                if (s) begin
                    pick = $urandom_range(0, 4);
                    if (pick < 2)       d = ADDR_A;
                    else if (pick < 4)  d = ADDR_B;
                end
                cycle(d, s, e, r);
            end
        end
        drain(words, first);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
